// File: rtl/midori128_pkg.sv
// Shared types and constants for the Midori128 round controller: FSM states,
// cell geometry and the round-constant table with its per-cell expansion.
package midori128_pkg;

  localparam int CELL_W = 8;
  localparam int NCELLS = 16;
  localparam int NRC    = 19;

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

  // beta_0 sits in the low 16 bits; bit 15 of each entry belongs to cell 0
  localparam logic [NRC-1:0][15:0] BETA = {
    16'h628A, 16'h23B4, 16'h1C24, 16'h7C81, 16'hDF90, 16'hF8CA, 16'h5130,
    16'h228E, 16'h7197, 16'h40B8, 16'h9481, 16'h0BCC, 16'h0266, 16'hD170,
    16'h104F, 16'h6213, 16'hA435, 16'h78C0, 16'h15B3
  };

  // Drops beta bit j into the LSB of cell j; cell 0 occupies bits [127:120]
  function automatic logic [127:0] rc_expand(input logic [15:0] beta);
    logic [127:0] m;
    m = '0;
    for (int j = 0; j < NCELLS; j++) m[(NCELLS-1-j)*CELL_W] = beta[15-j];
    return m;
  endfunction

endpackage

// File: rtl/midori128_rc_rom.sv
// Round index to expanded 128-bit round constant; indices past the table read as zero.
module midori128_rc_rom
  import midori128_pkg::*;
(
  input  logic [4:0]   rnd,
  output logic [127:0] rc
);

  always_comb begin
    rc = '0;
    if (rnd < 5'(NRC)) rc = rc_expand(BETA[rnd]);
  end

endmodule

// File: rtl/midori128_round_ctrl.sv
// Iterative Midori128 controller: owns state and key registers, sequences
// ROUNDS-1 full rounds plus a final round around the external round datapath.
module midori128_round_ctrl
  import midori128_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic [127:0] sc_state,
  input  logic [127:0] sb_ret,
  input  logic [127:0] mc_ret,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS - 2);

  state_t       state_q, state_d;
  logic [127:0] s_q, s_d;
  logic [127:0] k_q, k_d;
  logic [4:0]   rnd_q, rnd_d;
  logic [127:0] rc;

  midori128_rc_rom u_rc_rom (
    .rnd (rnd_q),
    .rc  (rc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = pt ^ key;
          k_d     = key;
          rnd_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d = mc_ret ^ k_q ^ rc;
        // Counter parks at the last full round so it never exceeds ROUNDS-2
        if (rnd_q == LAST_RND) state_d = FINAL;
        else                   rnd_d   = rnd_q + 5'd1;
      end
      FINAL: begin
        s_d     = sb_ret ^ k_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sc_state  = s_q;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == FINAL);
  assign out_valid = (state_q == DONE);
  // Gated so the output never exposes intermediate round state
  assign ct        = out_valid ? s_q : '0;

endmodule

// File: tb/tb_midori128_round_ctrl.sv
// Directed bench: wraps the controller with SubCells/ShuffleCell/MixColumn
// models and checks published vectors, timing, backpressure and reset.
module tb_midori128_round_ctrl;

  localparam logic [127:0] ZERO_CT = 128'hc055cbb95996d14902b60574d5e728d6;
  localparam logic [127:0] STD_PT  = 128'h51084ce6e73a5ca2ec87d7babc297543;
  localparam logic [127:0] STD_KEY = 128'h687ded3b3c85b3f35b1009863e2a8cbf;
  localparam logic [127:0] STD_CT  = 128'h1e0ac4fddff71b4c1801b73ee4afc83d;

  localparam logic [0:15][3:0] SB1_T = {4'h1, 4'h0, 4'h5, 4'h3, 4'he, 4'h2, 4'hf, 4'h7,
                                        4'hd, 4'ha, 4'h9, 4'hb, 4'hc, 4'h8, 4'h4, 4'h6};
  localparam logic [0:3][0:7][2:0] SSB_P = {
    {3'd4, 3'd1, 3'd6, 3'd3, 3'd0, 3'd5, 3'd2, 3'd7},
    {3'd1, 3'd6, 3'd7, 3'd0, 3'd5, 3'd2, 3'd3, 3'd4},
    {3'd2, 3'd3, 3'd4, 3'd1, 3'd6, 3'd7, 3'd0, 3'd5},
    {3'd7, 3'd4, 3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd6}
  };
  localparam logic [0:15][3:0] SHUF = {4'd0, 4'd10, 4'd5, 4'd15, 4'd14, 4'd4, 4'd11, 4'd1,
                                       4'd9, 4'd3, 4'd12, 4'd6, 4'd7, 4'd13, 4'd2, 4'd8};
  localparam logic [0:18][15:0] BETA_T = {
    16'h15B3, 16'h78C0, 16'hA435, 16'h6213, 16'h104F, 16'hD170, 16'h0266,
    16'h0BCC, 16'h9481, 16'h40B8, 16'h7197, 16'h228E, 16'h5130, 16'hF8CA,
    16'hDF90, 16'h7C81, 16'h1C24, 16'h23B4, 16'h628A
  };

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready, busy, stub;
  logic [127:0] pt, key, sc_state, sb_ret, mc_ret, ct;

  int n_checks = 0;
  int n_errors = 0;

  midori128_round_ctrl #(.ROUNDS(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .key       (key),
    .sc_state  (sc_state),
    .sb_ret    (sb_ret),
    .mc_ret    (mc_ret),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct        (ct),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ssb(input logic [7:0] x, input logic [1:0] i);
    logic [7:0] n, m, y;
    n = '0;
    y = '0;
    for (int k = 0; k < 8; k++) n[7-k] = x[7-SSB_P[i][k]];
    m = {SB1_T[n[7:4]], SB1_T[n[3:0]]};
    for (int k = 0; k < 8; k++) y[7-SSB_P[i][k]] = m[7-k];
    return y;
  endfunction

  function automatic logic [127:0] subcells(input logic [127:0] s);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = ssb(s[127-8*j -: 8], 2'(j % 4));
    return o;
  endfunction

  function automatic logic [127:0] shuffle(input logic [127:0] s);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[127-8*int'(SHUF[j]) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixcol(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   t;
    for (int c = 0; c < 4; c++) begin
      t = s[127-32*c -: 8] ^ s[119-32*c -: 8] ^ s[111-32*c -: 8] ^ s[103-32*c -: 8];
      for (int r = 0; r < 4; r++) o[127-32*c-8*r -: 8] = t ^ s[127-32*c-8*r -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] exp_rc(input int i);
    logic [127:0] m;
    logic [15:0]  b;
    m = '0;
    b = BETA_T[i];
    for (int j = 0; j < 16; j++) m[127-8*j-7] = b[15-j];
    return m;
  endfunction

  always_comb begin
    sb_ret = stub ? '0 : subcells(sc_state);
    mc_ret = stub ? '0 : mixcol(shuffle(subcells(sc_state)));
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one block and returns just after the accept edge
  task automatic start(input logic [127:0] p, input logic [127:0] k);
    in_valid = 1'b1;
    pt       = p;
    key      = k;
    tick();
    in_valid = 1'b0;
  endtask

  // Cycle index 1 is the cycle right after the accept edge
  task automatic wait_out(output int cyc, output int busy_n, output int rdy_n);
    cyc    = 1;
    busy_n = 0;
    rdy_n  = 0;
    while (!out_valid && cyc < 60) begin
      if (busy) busy_n++;
      if (in_ready) rdy_n++;
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc, busy_n, rdy_n, nacc, nout, nvld;
    int acc [4];
    logic [127:0] vp [4];
    logic [127:0] vk [4];
    logic [127:0] vc [4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stub = 1'b0;
    pt = '0; key = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ct", ct, '0);
    chk("rst_state", sc_state, '0);

    // Zero vector with latency check
    start('0, '0);
    wait_out(cyc, busy_n, rdy_n);
    chk("zero_out_valid", 128'(out_valid), 128'd1);
    chk("zero_latency", 128'(cyc), 128'd21);
    chk("zero_ct", ct, ZERO_CT);
    tick();
    chk("zero_back_idle", 128'(in_ready), 128'd1);

    // Standard vector with busy / in_ready profile
    start(STD_PT, STD_KEY);
    wait_out(cyc, busy_n, rdy_n);
    chk("std_ct", ct, STD_CT);
    chk("std_busy_cycles", 128'(busy_n), 128'd20);
    chk("std_in_ready_low", 128'(rdy_n), 128'd0);
    tick();

    // Backpressure in DONE with a competing block offered
    out_ready = 1'b0;
    start('0, '0);
    wait_out(cyc, busy_n, rdy_n);
    in_valid = 1'b1; pt = STD_PT; key = STD_KEY;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_ct_hold", ct, ZERO_CT);
      chk("bp_valid_hold", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_ready", 128'(in_ready), 128'd1);
    chk("bp_idle_valid", 128'(out_valid), 128'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_second_taken", 128'(busy), 128'd1);
    wait_out(cyc, busy_n, rdy_n);
    chk("bp_second_ct", ct, STD_CT);
    tick();

    // Reset during RUN round 7
    start(STD_PT, STD_KEY);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_state", sc_state, '0);
    start('0, '0);
    wait_out(cyc, busy_n, rdy_n);
    chk("mid_rst_zero_ct", ct, ZERO_CT);
    tick();

    // Back-to-back with in_valid and out_ready tied high
    vp[0] = '0;     vk[0] = '0;      vc[0] = ZERO_CT;
    vp[1] = STD_PT; vk[1] = STD_KEY; vc[1] = STD_CT;
    vp[2] = '0;     vk[2] = '0;      vc[2] = ZERO_CT;
    vp[3] = STD_PT; vk[3] = STD_KEY; vc[3] = STD_CT;
    nacc = 0; nout = 0; nvld = 0;
    in_valid = 1'b1; pt = vp[0]; key = vk[0];
    for (int c = 0; c < 110; c++) begin
      if (in_ready && in_valid && nacc < 4) begin
        acc[nacc] = c;
        nacc++;
      end
      if (out_valid) begin
        nvld++;
        if (nout < 4) chk($sformatf("b2b_ct%0d", nout), ct, vc[nout]);
        nout++;
      end
      tick();
      if (nacc < 4) begin
        pt = vp[nacc]; key = vk[nacc];
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("b2b_accepts", 128'(nacc), 128'd4);
    chk("b2b_out_count", 128'(nvld), 128'd4);
    for (int k = 1; k < 4; k++)
      if (k < nacc) chk($sformatf("b2b_spacing%0d", k), 128'(acc[k] - acc[k-1]), 128'd22);

    // Round constants with the datapath stubbed to zero
    stub = 1'b1;
    start('0, '0);
    chk("rc_initial", sc_state, '0);
    for (int i = 0; i < 19; i++) begin
      tick();
      chk($sformatf("rc_round%0d", i), sc_state, exp_rc(i));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stub = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/midori128_round_ctrl.md
Name: midori128_round_ctrl

Overview:
Iterative Midori128 encryption controller and state register. It sits directly upstream of SubCells. It holds the 128-bit cipher state and key, applies whitening, round-key and round-constant addition, and sequences the rounds. Its state output drives SubCells. It takes back two results: the SubCells output, and the full-round output from SubCells→ShuffleCell→MixColumn. Block-level valid/ready handshakes are provided on the input and output sides.

Parameters:
ROUNDS, 20, total rounds: ROUNDS-1 full rounds plus 1 final round. Must be 20 for spec compliance; values 2..20 are allowed for debug only.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  plaintext/key offered
in_ready  out  1  block can accept; high only in IDLE
pt  in  128  plaintext; cell 0 = bits [127:120], cell j = bits [127-8j -: 8]
key  in  128  key K, same cell layout
sc_state  out  128  current state register S, wired to the SubCells input
sb_ret  in  128  SubCells output, combinational from sc_state
mc_ret  in  128  MixColumn(ShuffleCell(SubCells(sc_state))), combinational
out_valid  out  1  ciphertext valid; held until accepted
out_ready  in  1  downstream accepts
ct  out  128  ciphertext; equals S while out_valid
busy  out  1  high in RUN or FINAL

Behaviour:
- Reset (clk edge with rst=1) forces:
  - FSM to IDLE, S=0, Kreg=0, rnd=0
  - out_valid=0, busy=0, in_ready=1 (the next cycle)
  - Reset overrides any handshake in progress in any state, including mid-RUN and DONE.
- FSM states: IDLE, RUN, FINAL, DONE. rnd is a 5-bit counter.
- IDLE:
  - in_ready=1.
  - On in_valid: S<=pt^key, Kreg<=key, rnd<=0, go to RUN (to FINAL if ROUNDS==1 would apply; ROUNDS>=2, so RUN).
- RUN, one round per cycle:
  - S <= mc_ret ^ Kreg ^ RC(rnd).
  - RC(i) XORs beta_i bit j into the LSB of cell j, for j=0..15. Bit j is counted MSB-first from the 16-bit constant.
  - rnd <= rnd+1. When rnd == ROUNDS-2, go to FINAL instead of staying in RUN.
- FINAL:
  - S <= sb_ret ^ Kreg (no ShuffleCell/MixColumn, no constant).
  - Go to DONE.
- DONE:
  - out_valid=1, ct=S.
  - S, ct and out_valid are held stable while out_ready=0.
  - On out_ready: go to IDLE. Next accept is possible one cycle later (no bypass).
- in_ready is 0 outside IDLE. in_valid in RUN, FINAL or DONE is ignored; no queueing.
- Latency with ROUNDS=20: accept edge at cycle 0, 19 RUN cycles, 1 FINAL, out_valid high from cycle 21. Throughput is one block per 22 cycles when out_ready is held at 1.
- sc_state always equals S. The combinational path S→SubCells→Shuffle→Mix→XOR→S must close in one cycle.
- rnd never exceeds ROUNDS-2. It is unused outside RUN and is cleared on accept.
- Kreg is changed only on accept.
- ct is 0 after reset until the first DONE.

Decomposition:
- Package midori128_pkg holds:
  - the 19×16-bit round constant table beta_0..beta_18, with values per the Midori specification
  - the state_t enum {IDLE, RUN, FINAL, DONE}
  - CELL_W=8 and NCELLS=16
  - a function rc_expand(beta) returning the 128-bit mask that has bit 8j+0 of cell j set
- One natural sub-module: midori128_rc_rom, mapping rnd (5 b) to the 128-bit expanded constant, combinational.
- The testbench wraps this block with the existing SubCells, ShuffleCell and MixColumn modules to form the full cipher.

Test Plan:
- Zero vector: pt=0, key=0, in_valid pulse, out_ready=1 → ct=c055cbb95996d14902b60574d5e728d6, out_valid rising exactly 21 cycles after the accept edge.
- Standard vector: pt=51084ce6e73a5ca2ec87d7babc297543, key=687ded3b3c85b3f35b1009863e2a8cbf → ct=1e0ac4fddff71b4c1801b73ee4afc83d. busy=1 for 20 cycles and in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and a different pt → ct and out_valid stable, in_ready=0, second block not taken. After out_ready=1, the second block is accepted one cycle after the return to IDLE and yields its own correct ct.
- Reset mid-operation: assert rst at RUN round 7 → next cycle IDLE, S=0, out_valid=0, in_ready=1. A fresh zero vector then still gives c055cbb9….
- Back-to-back: 4 blocks with in_valid and out_ready tied to 1 → 4 correct ciphertexts, accepts spaced 22 cycles apart, no dropped or duplicated out_valid.
- Constant check: drive mc_ret=0 and sb_ret=0 via a stub, key=0 → after RUN cycle i, S equals rc_expand(beta_i) exactly.
